// File: rtl/uart_pkg.sv
// Shared types and helpers for the multi-word UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   localparam int MIN_DIV  = 2;
   localparam int MAX_BITS = 9;

   // Words narrower than MAX_BITS are zero-extended, which leaves the XOR unchanged.
   function automatic logic parity_bit(input logic [MAX_BITS-1:0] w, input parity_e mode);
      return (^w) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_multi_if.sv
// Transaction handshake plus per-transaction frame configuration.
interface uart_tx_multi_if
   import uart_pkg::*;
#(
   parameter int NUM_WORDS     = 3,
   parameter int BITS_PER_WORD = 8,
   parameter int DIV_W         = 16
);
   logic                                 s_valid;
   logic                                 s_ready;
   logic [NUM_WORDS*BITS_PER_WORD-1:0]   s_data;
   logic [DIV_W-1:0]                     cfg_div;
   parity_e                              cfg_parity;
   logic                                 cfg_stop2;

   modport master (
      output s_valid, s_data, cfg_div, cfg_parity, cfg_stop2,
      input  s_ready
   );

   modport slave (
      input  s_valid, s_data, cfg_div, cfg_parity, cfg_stop2,
      output s_ready
   );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: strobes bit_end on the last clock of every div-clock period while enabled.
module uart_bit_timer #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             bit_end
);

   logic [DIV_W-1:0] cnt;

   assign bit_end = en && (cnt == div - DIV_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!en || bit_end)
         cnt <= '0;
      else
         cnt <= cnt + DIV_W'(1);
   end

endmodule

// File: rtl/uart_tx_multi.sv
// Multi-word UART transmitter: serialises NUM_WORDS words per transaction, word 0 first,
// with frame format and divisor latched at the handshake.
module uart_tx_multi
   import uart_pkg::*;
#(
   parameter int NUM_WORDS     = 3,
   parameter int BITS_PER_WORD = 8,
   parameter int DIV_W         = 16
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_multi_if.slave  bus,
   output logic            tx,
   output logic            busy,
   output logic            done
);

   localparam int WORD_W = NUM_WORDS * BITS_PER_WORD;
   localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int BCNT_W = $clog2(BITS_PER_WORD + 1);

   state_e                   state, state_nxt;
   logic [WORD_W-1:0]        data_q;
   logic [DIV_W-1:0]         div_q, div_eff;
   parity_e                  par_q, par_eff;
   logic                     stop2_q;
   logic [BITS_PER_WORD-1:0] sh, sh_nxt, cur_word;
   logic [BCNT_W-1:0]        bit_cnt, bit_nxt;
   logic                     stop_cnt, stop_nxt;
   logic [IDX_W-1:0]         word_idx, word_nxt;
   logic                     load, tx_nxt, done_nxt, timer_en, bit_end;

   assign bus.s_ready = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);
   assign timer_en    = (state != ST_IDLE);
   assign cur_word    = data_q[int'(word_idx)*BITS_PER_WORD +: BITS_PER_WORD];

   assign div_eff = (bus.cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.cfg_div;
   assign par_eff = (bus.cfg_parity == PAR_EVEN || bus.cfg_parity == PAR_ODD) ?
                    bus.cfg_parity : PAR_NONE;

   uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (timer_en),
      .div     (div_q),
      .bit_end (bit_end)
   );

   always_comb begin
      state_nxt = state;
      sh_nxt    = sh;
      bit_nxt   = bit_cnt;
      stop_nxt  = stop_cnt;
      word_nxt  = word_idx;
      load      = 1'b0;
      unique case (state)
         ST_IDLE: if (bus.s_valid) begin
            load      = 1'b1;
            word_nxt  = '0;
            state_nxt = ST_START;
         end
         ST_START: if (bit_end) begin
            sh_nxt    = cur_word;
            bit_nxt   = '0;
            state_nxt = ST_DATA;
         end
         ST_DATA: if (bit_end) begin
            if (bit_cnt == BCNT_W'(BITS_PER_WORD - 1)) begin
               bit_nxt   = '0;
               state_nxt = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
               bit_nxt = bit_cnt + BCNT_W'(1);
               sh_nxt  = sh >> 1;
            end
         end
         ST_PARITY: if (bit_end) begin
            stop_nxt  = 1'b0;
            state_nxt = ST_STOP;
         end
         ST_STOP: if (bit_end) begin
            if (stop2_q && !stop_cnt) begin
               stop_nxt = 1'b1;
            end else begin
               stop_nxt = 1'b0;
               if (word_idx == IDX_W'(NUM_WORDS - 1)) begin
                  state_nxt = ST_IDLE;
               end else begin
                  word_nxt  = word_idx + IDX_W'(1);
                  state_nxt = ST_START;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // tx is registered, so it is computed from where the FSM is heading.
      unique case (state_nxt)
         ST_START:  tx_nxt = 1'b0;
         ST_DATA:   tx_nxt = sh_nxt[0];
         ST_PARITY: tx_nxt = parity_bit(MAX_BITS'(cur_word), par_q);
         default:   tx_nxt = 1'b1;
      endcase
      done_nxt = (state != ST_IDLE) && (state_nxt == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         data_q   <= '0;
         div_q    <= '0;
         par_q    <= PAR_NONE;
         stop2_q  <= 1'b0;
         sh       <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         word_idx <= '0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         sh       <= sh_nxt;
         bit_cnt  <= bit_nxt;
         stop_cnt <= stop_nxt;
         word_idx <= word_nxt;
         tx       <= tx_nxt;
         done     <= done_nxt;
         if (load) begin
            data_q  <= bus.s_data;
            div_q   <= div_eff;
            par_q   <= par_eff;
            stop2_q <= bus.cfg_stop2;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_multi.sv
// Bench for uart_tx_multi: per-clock waveform model built from frame rules, plus directed pins.
module tb_uart_tx_multi;
   import uart_pkg::*;

   localparam int NW  = 3;
   localparam int BPW = 8;
   localparam int DW  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx, busy, done;

   uart_tx_multi_if #(.NUM_WORDS(NW), .BITS_PER_WORD(BPW), .DIV_W(DW)) bus();

   uart_tx_multi #(.NUM_WORDS(NW), .BITS_PER_WORD(BPW), .DIV_W(DW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .tx   (tx),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One frame as a bit vector, bit i = i-th bit on the line.
   function automatic logic [15:0] frame_vec(input logic [BPW-1:0] w, input logic [1:0] par,
                                             input logic stop2, output int n);
      logic [15:0] v;
      v = '0;
      n = 0;
      v[n] = 1'b0; n++;
      for (int i = 0; i < BPW; i++) begin v[n] = w[i]; n++; end
      if (par == 2'd1 || par == 2'd2) begin
         v[n] = (($countones(w) % 2) == 1) ^ (par == 2'd2);
         n++;
      end
      v[n] = 1'b1; n++;
      if (stop2) begin v[n] = 1'b1; n++; end
      return v;
   endfunction

   bit   mq[$];
   logic m_busy = 1'b0;
   logic m_tx   = 1'b1;
   logic m_done = 1'b0;

   task automatic model_load(input logic [NW*BPW-1:0] d, input logic [DW-1:0] div,
                             input logic [1:0] par, input logic s2);
      int dd;
      int n;
      logic [15:0] v;
      dd = (div < 2) ? 2 : int'(div);
      for (int w = 0; w < NW; w++) begin
         v = frame_vec(d[w*BPW +: BPW], par, s2, n);
         for (int b = 0; b < n; b++)
            for (int c = 0; c < dd; c++) mq.push_back(v[b]);
      end
   endtask

   // Model: the line value for every clock of a transaction, queued at acceptance.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         mq.delete();
         m_busy = 1'b0;
         m_tx   = 1'b1;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            if (mq.size() == 0) begin
               m_busy = 1'b0;
               m_tx   = 1'b1;
               m_done = 1'b1;
            end else begin
               m_tx = mq.pop_front();
            end
         end else if (bus.s_valid) begin
            model_load(bus.s_data, bus.cfg_div, bus.cfg_parity, bus.cfg_stop2);
            m_busy = 1'b1;
            m_tx   = mq.pop_front();
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("tx", tx, m_tx);
      chk("busy", busy, m_busy);
      chk("s_ready", bus.s_ready, !m_busy);
      chk("done", done, m_done);
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.s_ready && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   // Returns #1 after the accepting edge (cycle 0 of the transaction).
   task automatic send(input logic [NW*BPW-1:0] d, input logic [DW-1:0] div,
                       input logic [1:0] par, input logic s2, input logic hold);
      int n;
      bus.s_data     = d;
      bus.cfg_div    = div;
      bus.cfg_parity = parity_e'(par);
      bus.cfg_stop2  = s2;
      bus.s_valid    = 1'b1;
      n = 0;
      while (!bus.s_ready && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!hold) bus.s_valid = 1'b0;
   endtask

   task automatic measure(output int n);
      n = 0;
      while (n < 2000 && !done) begin @(posedge clk); #1; n++; end
   endtask

   initial begin
      int n;
      logic [15:0] v;
      logic [9:0]  lit;
      logic        hold, prev_hold;
      bus.s_valid    = 1'b0;
      bus.s_data     = '0;
      bus.cfg_div    = 16'd4;
      bus.cfg_parity = PAR_NONE;
      bus.cfg_stop2  = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", bus.s_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      rst = 1'b0;

      v = frame_vec(8'h55, 2'd1, 1'b1, n);
      chk("pin_even_frame", 32'(v[11:0]), 32'hCAA);
      chk("pin_even_len", n, 12);
      v = frame_vec(8'h55, 2'd2, 1'b1, n);
      chk("pin_odd_frame", 32'(v[11:0]), 32'hEAA);
      v = frame_vec(8'h55, 2'd0, 1'b0, n);
      chk("pin_none_frame", 32'(v[9:0]), 32'h2AA);
      chk("pin_none_len", n, 10);

      // Basic frame: word 0 bit-by-bit against literals, then total length.
      wait_idle();
      send({8'hC3, 8'hA5, 8'h55}, 16'd4, 2'd0, 1'b0, 1'b0);
      lit = 10'h2AA;
      n = 0;
      while (n < 400 && !done) begin
         if (n < 40 && (n % 4) == 2) chk("basic_bit", tx, lit[n/4]);
         @(posedge clk); #1; n++;
      end
      chk("basic_len", n, 120);
      chk("basic_ready", bus.s_ready, 1'b1);

      // Parity bit sits in cycles 36..39, stop bits in 40..47.
      wait_idle();
      send({8'h0F, 8'h3C, 8'h55}, 16'd4, 2'd1, 1'b1, 1'b0);
      repeat (37) @(posedge clk); #1;
      chk("even_parity", tx, 1'b0);
      repeat (8) @(posedge clk); #1;
      chk("stop2_level", tx, 1'b1);
      measure(n);
      chk("even_stop2_len", n, 144 - 45);
      wait_idle();
      send({8'h0F, 8'h3C, 8'h55}, 16'd4, 2'd2, 1'b1, 1'b0);
      repeat (37) @(posedge clk); #1;
      chk("odd_parity", tx, 1'b1);

      for (int dv = 0; dv < 3; dv++) begin
         wait_idle();
         send({8'h81, 8'h7E, 8'h3A}, 16'(dv), 2'd0, 1'b0, 1'b0);
         measure(n);
         chk("div_clamp_len", n, 60);
      end

      // Config latch: mid-transaction changes must not be seen.
      wait_idle();
      send({8'h12, 8'h34, 8'h56}, 16'd4, 2'd0, 1'b0, 1'b0);
      bus.cfg_div = 16'd10;
      bus.s_data  = 24'hFFFFFF;
      measure(n);
      chk("latch_len", n, 120);

      // Back-to-back with valid held high.
      wait_idle();
      send({8'hDE, 8'hAD, 8'hBE}, 16'd3, 2'd1, 1'b0, 1'b1);
      send({8'h01, 8'h80, 8'hF0}, 16'd3, 2'd1, 1'b0, 1'b0);
      measure(n);
      chk("b2b_len", n, 99);

      // Reset in word 1 data bit 3 (cycles 56..59).
      wait_idle();
      send({8'hAA, 8'h00, 8'hFF}, 16'd4, 2'd0, 1'b0, 1'b0);
      repeat (57) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_ready", bus.s_ready, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      wait_idle();
      send({8'h11, 8'h22, 8'h33}, 16'd4, 2'd0, 1'b0, 1'b0);
      measure(n);
      chk("post_rst_len", n, 120);

      prev_hold = 1'b0;
      for (int i = 0; i < 25; i++) begin
         hold = (i == 24) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
         if (!prev_hold) repeat ($urandom_range(0, 4)) @(negedge clk);
         send({8'($urandom), 8'($urandom), 8'($urandom)}, 16'($urandom_range(0, 5)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), hold);
         if (!hold && $urandom_range(0, 1) == 1) begin
            bus.s_data     = {8'($urandom), 8'($urandom), 8'($urandom)};
            bus.cfg_div    = 16'($urandom_range(0, 12));
            bus.cfg_parity = parity_e'(2'($urandom_range(0, 3)));
            bus.cfg_stop2  = 1'($urandom_range(0, 1));
         end
         prev_hold = hold;
      end

      wait_idle();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
